sr_pulse_seq: RTL

SR_PULSE_SEQ -- requirements
Module: sr_pulse_seq

---
 rtl/sr_pulse_seq.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/sr_pulse_seq.sv
// Sequencer that drives a downstream NOR SR latch with fixed-width s/r pulses,
// each followed by an idle gap, and checks the latch feedback afterwards.
module sr_pulse_seq #(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1,
    parameter int LOG          = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic set_req,
    input  logic clr_req,
    input  logic q_fb,
    output logic s,
    output logic r,
    output logic busy,
    output logic err,
    output logic conflict
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET_P = 2'd1,
        CLR_P = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [3:0] PULSE_LOAD = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYCLES - 1);

    // Out-of-range parameters are rejected when the design is elaborated.
    if (PULSE_CYCLES < 1 || PULSE_CYCLES > 15) begin : g_bad_pulse
        $error("sr_pulse_seq: PULSE_CYCLES must be 1..15");
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
        $error("sr_pulse_seq: GAP_CYCLES must be 1..15");
    end
    if (LOG < 0 || LOG > 1) begin : g_bad_log
        $error("sr_pulse_seq: LOG must be 0 or 1");
    end

    state_t     state_r, state_next_s;
    logic [3:0] cnt_r, cnt_next_s;
    logic       armed_r;
    logic       set_cur_r, set_prv_r, clr_cur_r, clr_prv_r;
    logic       pend_vld_r, pend_vld_next_s, pend_clr_r, pend_clr_next_s;
    logic       last_set_r, last_set_next_s;
    logic       err_r, err_next_s, conflict_r, conflict_next_s;
    logic       s_r, r_r, busy_r;
    logic       s_next_s, r_next_s, busy_next_s;
    logic       set_edge_s, clr_edge_s, any_edge_s;

    assign set_edge_s = set_cur_r & ~set_prv_r;
    assign clr_edge_s = clr_cur_r & ~clr_prv_r;
    assign any_edge_s = set_edge_s | clr_edge_s;

    // State, counter, edge-detect, pending, flag and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            armed_r    <= 1'b0;
            set_cur_r  <= 1'b0;
            set_prv_r  <= 1'b0;
            clr_cur_r  <= 1'b0;
            clr_prv_r  <= 1'b0;
            pend_vld_r <= 1'b0;
            pend_clr_r <= 1'b0;
            last_set_r <= 1'b0;
            err_r      <= 1'b0;
            conflict_r <= 1'b0;
            s_r        <= 1'b0;
            r_r        <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            // First cycle after release loads both samples so a level held
            // through reset is never mistaken for a rising edge.
            armed_r    <= 1'b1;
            set_cur_r  <= set_req;
            clr_cur_r  <= clr_req;
            set_prv_r  <= armed_r ? set_cur_r : set_req;
            clr_prv_r  <= armed_r ? clr_cur_r : clr_req;
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            pend_vld_r <= pend_vld_next_s;
            pend_clr_r <= pend_clr_next_s;
            last_set_r <= last_set_next_s;
            err_r      <= err_next_s;
            conflict_r <= conflict_next_s;
            s_r        <= s_next_s;
            r_r        <= r_next_s;
            busy_r     <= busy_next_s;
        end
    end

    // Next-state logic: dispatch from IDLE, time pulses and gaps, check feedback.
    always_comb begin
        state_next_s    = state_r;
        cnt_next_s      = cnt_r;
        last_set_next_s = last_set_r;
        err_next_s      = err_r;
        conflict_next_s = conflict_r | (set_edge_s & clr_edge_s);
        case (state_r)
            IDLE: begin
                if (any_edge_s) begin
                    state_next_s    = clr_edge_s ? CLR_P : SET_P;
                    cnt_next_s      = PULSE_LOAD;
                    last_set_next_s = ~clr_edge_s;
                end else if (pend_vld_r) begin
                    state_next_s    = pend_clr_r ? CLR_P : SET_P;
                    cnt_next_s      = PULSE_LOAD;
                    last_set_next_s = ~pend_clr_r;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SET_P, CLR_P: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = GAP;
                    cnt_next_s   = GAP_LOAD;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            GAP: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = IDLE;
                    cnt_next_s   = 4'd0;
                    err_next_s   = err_r | (q_fb ^ last_set_r);
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // One-deep pending slot: filled (latest wins) while busy, always emptied in IDLE.
    always_comb begin
        pend_vld_next_s = pend_vld_r;
        pend_clr_next_s = pend_clr_r;
        if (state_r == IDLE) begin
            pend_vld_next_s = 1'b0;
        end else if (any_edge_s) begin
            pend_vld_next_s = 1'b1;
            pend_clr_next_s = clr_edge_s;
        end else begin
            pend_vld_next_s = pend_vld_r;
        end
    end

    // Output decode from the next state so s/r/busy come straight from flops.
    always_comb begin
        s_next_s    = (state_next_s == SET_P);
        r_next_s    = (state_next_s == CLR_P);
        busy_next_s = (state_next_s != IDLE);
    end

    assign s        = s_r;
    assign r        = r_r;
    assign busy     = busy_r;
    assign err      = err_r;
    assign conflict = conflict_r;

endmodule
